// File: rtl/shift_chain_ctrl_pkg.sv
// Shared definitions for the shift-chain sequencer.
//   state_e    : controller states (IDLE, RUN, DONE), 2-bit encoding
//   cnt_width  : run-counter width for a given word width and chain depth
package shift_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold 0 .. width+depth-1 inclusive.
  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

// File: rtl/shift_chain_ctrl_dff_chain.sv
// DEPTH-stage posedge D-flip-flop shift chain.
//   clk : clock          rst : async reset, active-high
//   en  : shift enable   clr : synchronous clear (wins over en)
//   d   : serial input   q   : stage outputs, q[DEPTH-1] is the tail
module dff_chain #(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  output logic [DEPTH-1:0] q
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic d_in;

    if (i == 0) begin : g_head
      assign d_in = d;
    end else begin : g_body
      assign d_in = q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q[i] <= 1'b0;
      end else if (clr) begin
        q[i] <= 1'b0;
      end else if (en) begin
        q[i] <= d_in;
      end
    end
  end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Sequencer for a DEPTH-stage shift chain: accepts a parallel word, drives it
// MSB-first through the chain, reassembles the bits leaving the tail and
// presents the word on an output handshake.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : input word handshake, in_data word
//   abort                : synchronous abort, honoured only while running
//   out_valid/out_ready  : output word handshake, out_data word
//   busy                 : high while running or holding a result
//   ser_tap              : chain tail, for observation
module shift_chain_ctrl
  import shift_chain_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             ser_tap
);

  localparam int unsigned CNT_W = cnt_width(WIDTH, DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH + DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] assy_q, assy_d;
  logic             chain_en, chain_clr;
  logic [DEPTH-1:0] chain_q;
  logic             chain_unused;

  dff_chain #(.DEPTH(DEPTH)) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (chain_en),
    .clr (chain_clr),
    .d   (load_q[WIDTH-1]),
    .q   (chain_q)
  );

  assign ser_tap = chain_q[DEPTH-1];
  // Inner stages exist only for the chain itself; the tail is the observable bit.
  assign chain_unused = &chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      assy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      assy_q  <= assy_d;
    end
  end

  // The load register shifts left each run cycle, so its MSB is the chain
  // input and it has already emptied to 0 once all WIDTH bits are sent.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    assy_d    = assy_q;
    chain_en  = 1'b0;
    chain_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_d  = in_data;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        chain_en = 1'b1;
        load_d   = load_q << 1;
        if (cnt_q >= CNT_FIRST) begin
          assy_d = (assy_q << 1) | WIDTH'(ser_tap);
        end
        if (abort) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          load_d    = '0;
          assy_d    = '0;
          chain_clr = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d   = ST_IDLE;
          chain_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  // Assembly register is mid-shift during a run; only expose it when complete.
  assign out_data  = out_valid ? assy_q : '0;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
module tb_shift_chain_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             ser_tap;

  shift_chain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .abort     (abort),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .ser_tap   (ser_tap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ab;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_busy;
    logic       e_tap;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ab,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [7:0] e_od, input logic e_busy, input logic e_tap);
    vec_t v;
    v.iv = iv; v.id = id; v.ab = ab; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_busy = e_busy; v.e_tap = e_tap;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ir, input logic ov,
                            input logic [7:0] od, input logic bz, input logic tap);
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"},  32'(out_data),  32'(od));
    check({tag, ".busy"},      32'(busy),      32'(bz));
    check({tag, ".ser_tap"},   32'(ser_tap),   32'(tap));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int t1;
    int t2;
    logic seen_ov;

    // Accept A5 then send MSB-first: taps 1,0,1,0,0,1,0,1 two edges after accept.
    vecs[0]  = mk(1, 8'hA5, 0, 0,  0, 0, 8'h00, 1, 0);
    vecs[1]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 1);
    vecs[3]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
    vecs[4]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 1);
    vecs[5]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
    vecs[6]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
    vecs[7]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 1);
    vecs[8]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 0);
    vecs[9]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 1);
    vecs[10] = mk(0, 8'h00, 0, 0,  0, 1, 8'hA5, 1, 0);
    // Held result while out_ready low; in_valid and abort ignored in DONE.
    vecs[11] = mk(0, 8'h00, 0, 0,  0, 1, 8'hA5, 1, 0);
    vecs[12] = mk(1, 8'h11, 0, 0,  0, 1, 8'hA5, 1, 0);
    vecs[13] = mk(0, 8'h00, 1, 0,  0, 1, 8'hA5, 1, 0);
    vecs[14] = mk(0, 8'h00, 0, 0,  0, 1, 8'hA5, 1, 0);
    vecs[15] = mk(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    #1;
    check_outs("reset", 1, 0, 8'h00, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      abort     = vecs[i].ab;
      out_ready = vecs[i].ordy;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                 vecs[i].e_busy, vecs[i].e_tap);
    end
    in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;

    // Abort at cnt=4.
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outs("abort", 1, 0, 8'h00, 0, 0);
    seen_ov = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid !== 1'b0) seen_ov = 1'b1;
    end
    check("abort_no_out_valid", 32'(seen_ov), 32'd0);

    // Async reset at cnt=6, no clock edge involved.
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check_outs("rst_mid", 1, 0, 8'h00, 0, 0);
    #1;
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("rst_recover_latency", 32'(k), 32'd10);
    check("rst_recover_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-to-back 00 then FF.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_data = 8'hFF;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    t1 = cyc;
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    check("b2b_first_data", 32'(out_data), 32'h00);
    tick();
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    t2 = cyc;
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_data", 32'(out_data), 32'hFF);
    check("b2b_spacing", 32'(t2 - t1), 32'd12);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check_outs("b2b_end", 1, 0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
